clk_gen_div: RTL and testbench
==============================

Name: clk_gen_div

Overview:
- Programmable, glitch-free clock divider that consumes the ring-oscillator output of the tunable clock generator.
- The oscillator loop output drives `clk`.
- Produces a divided, 50%-duty `clk_out` with a clean start/stop under `en_in`.
- Accepts new divide ratios through a valid/ready handshake; a new ratio takes effect only on a period boundary.
- Also provides a wrapping count of completed output periods for frequency observation.

Parameters:
- DIV_WIDTH, 8, width of the half-period divide value.
- DIV_RESET, 0, divide value loaded at reset (0 = divide-by-2).
- CNT_WIDTH, 16, width of the output-period counter.

Ports:
- clk  in  1  ring-oscillator clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en_in  in  1  run request; 1 = generate clk_out, 0 = stop cleanly.
- cfg_valid_in  in  1  new divide value offered.
- cfg_div_in  in  DIV_WIDTH  offered divide value D; half-period = D+1 cycles.
- cfg_ready_out  out  1  pending slot free; a transfer occurs when valid&ready.
- clk_out  out  1  divided clock, registered.
- running_out  out  1  1 while in RUN_HI or RUN_LO.
- period_cnt_out  out  CNT_WIDTH  completed output periods, wraps.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, clk_out=0, running_out=0, period_cnt_out=0, cnt=0.
  - div_act=DIV_RESET, pending slot empty, so cfg_ready_out=1.
- Registers: div_act (active divide), pend (pending value plus full flag), cnt (DIV_WIDTH).
- cfg_ready_out = !pend_full, combinational from the flag.
- On valid&ready, pend <= cfg_div_in and pend_full <= 1.
- IDLE:
  - clk_out=0.
  - If pend_full and not starting this cycle: div_act <= pend, pend_full <= 0 on the same edge.
  - If en_in=1: next state RUN_HI, clk_out <= 1, cnt <= 0, using the current div_act.
- RUN_HI:
  - cnt increments each cycle.
  - When cnt==div_act: cnt <= 0, clk_out <= 0, go to RUN_LO.
  - en_in is ignored here; a high phase always completes.
- RUN_LO:
  - cnt increments each cycle.
  - When cnt==div_act: cnt <= 0 and period_cnt_out increments (wrap 2^CNT_WIDTH-1 -> 0).
    - If en_in=0: go to IDLE, clk_out stays 0.
    - Else: go to RUN_HI, clk_out <= 1; if pend_full, div_act <= pend and pend_full <= 0 (boundary apply).
- Output timing:
  - Period = 2*(div_act+1) clk cycles.
  - Duty is exactly 50%.
  - clk_out never glitches and never produces a partial phase.
- Latency:
  - en_in sampled 1 in IDLE at edge k gives clk_out=1 after edge k.
  - A stop request only takes effect at the end of a low phase.
- Simultaneous events:
  - A config accepted in the same cycle as a boundary is not applied at that boundary; it applies at the next boundary.
  - Start in the same cycle as a config accept: start uses the old div_act; the new value applies at the first RUN_LO->RUN_HI boundary.
  - A second valid while pend_full is stalled (ready=0); the offered value must be held by the source.
- D=0 gives divide-by-2; D=2^DIV_WIDTH-1 gives divide-by-2^(DIV_WIDTH+1). No overflow: cnt never exceeds div_act.
- Reset mid-operation: clk_out drops to 0 immediately (async), and all state returns to reset values.

Optional Feature:
- Macro CLK_GEN_DIV_SYNC_EN.
- Defined:
  - en_in passes through a 2-flop synchronizer clocked by clk, reset to 0.
  - Start and stop decisions use the synchronized value, adding 2 cycles of latency.
- Undefined: en_in is used directly; the source must be synchronous to clk.
- The cfg handshake is unaffected in both builds.

Test Plan:
- Reset with en_in=0 -> clk_out=0, running_out=0, cfg_ready_out=1, period_cnt_out=0; hold 20 cycles, no change.
- DIV_RESET=0, en_in=1 -> clk_out toggles every cycle (period 2); after 10 periods period_cnt_out=10.
- Accept cfg_div_in=3 while running D=0 -> cfg_ready_out=0 until the next RUN_LO->RUN_HI boundary, then period 8 (4 high / 4 low), cfg_ready_out back to 1.
- en_in=0 asserted 1 cycle into a high phase with D=2 -> high phase completes (3 cycles), low phase completes (3 cycles), clk_out stays 0, running_out=0, state IDLE.
- Set CNT_WIDTH=4, run 17 periods -> period_cnt_out reads 15, wraps to 0, then 1.
- reset_n pulsed low mid high-phase -> clk_out=0 asynchronously; after release with en_in=1, restart with D=DIV_RESET.

Source files
------------

// File: rtl/clk_gen_div_if.sv
// Divide-ratio configuration handshake for clk_gen_div: valid/ready transfer of a half-period value.
// master = ratio source, slave = clk_gen_div.
interface clk_gen_div_if #(
  parameter int DIV_WIDTH = 8
);
  logic                 cfg_valid_in;
  logic [DIV_WIDTH-1:0] cfg_div_in;
  logic                 cfg_ready_out;

  modport master (output cfg_valid_in, output cfg_div_in, input cfg_ready_out);
  modport slave  (input cfg_valid_in, input cfg_div_in, output cfg_ready_out);
endinterface

// File: rtl/clk_gen_div.sv
// Glitch-free 50%-duty programmable divider of the ring-oscillator clock, with boundary-aligned ratio
// updates and a wrapping output-period counter. Define CLK_GEN_DIV_SYNC_EN to add a 2-flop en_in synchronizer.
module clk_gen_div #(
  parameter int DIV_WIDTH = 8,
  parameter int DIV_RESET = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en_in,
  clk_gen_div_if.slave         cfg,
  output logic                 clk_out,
  output logic                 running_out,
  output logic [CNT_WIDTH-1:0] period_cnt_out
);

  localparam logic [DIV_WIDTH-1:0] DIV_INIT = DIV_WIDTH'(DIV_RESET);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_HI = 2'd1,
    RUN_LO = 2'd2
  } state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_div_act;
  logic [DIV_WIDTH-1:0] r_pend;
  logic                 r_pend_full;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_clk_out;
  logic                 r_running;
  logic [CNT_WIDTH-1:0] r_period_cnt;

  logic w_en;
  logic w_accept;
  logic w_cnt_done;

`ifdef CLK_GEN_DIV_SYNC_EN
  logic [1:0] r_en_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_en_sync <= 2'b00;
    else          r_en_sync <= {r_en_sync[0], en_in};
  end

  assign w_en = r_en_sync[1];
`else
  assign w_en = en_in;
`endif

  // The pending slot is the only back-pressure; accept and apply are mutually exclusive by construction.
  assign cfg.cfg_ready_out = !r_pend_full;
  assign w_accept          = cfg.cfg_valid_in && !r_pend_full;
  assign w_cnt_done        = (r_cnt == r_div_act);

  // NOTE: all state uses non-blocking assignments so every branch reads the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_div_act    <= DIV_INIT;
      r_pend       <= '0;
      r_pend_full  <= 1'b0;
      r_cnt        <= '0;
      r_clk_out    <= 1'b0;
      r_running    <= 1'b0;
      r_period_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_pend      <= cfg.cfg_div_in;
        r_pend_full <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_clk_out <= 1'b0;
          if (w_en) begin
            r_state   <= RUN_HI;
            r_clk_out <= 1'b1;
            r_running <= 1'b1;
            r_cnt     <= '0;
          end else if (r_pend_full) begin
            r_div_act   <= r_pend;
            r_pend_full <= 1'b0;
          end
        end

        RUN_HI: begin
          if (w_cnt_done) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_state   <= RUN_LO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RUN_LO: begin
          if (w_cnt_done) begin
            r_cnt        <= '0;
            r_period_cnt <= r_period_cnt + 1'b1;
            if (!w_en) begin
              r_state   <= IDLE;
              r_running <= 1'b0;
            end else begin
              r_state   <= RUN_HI;
              r_clk_out <= 1'b1;
              if (r_pend_full) begin
                r_div_act   <= r_pend;
                r_pend_full <= 1'b0;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_clk_out <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign clk_out        = r_clk_out;
  assign running_out    = r_running;
  assign period_cnt_out = r_period_cnt;

endmodule

// File: tb/tb_clk_gen_div.sv
// Self-checking bench for clk_gen_div: cycle scoreboard against a phase-length model, plus
// table-driven period measurements and hand-written start/stop/reset/wrap sequences.
module tb_clk_gen_div;

  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int LIMIT = 2000;
`ifdef CLK_GEN_DIV_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct packed {
    logic          clk_out;
    logic          running;
    logic          ready;
    logic [CW-1:0] pcnt;
  } exp_t;

  typedef struct {
    int div;
    int half;
    int periods;
  } vec_t;

  logic          clk;
  logic          reset_n;
  logic          en_in;
  logic          clk_out;
  logic          running_out;
  logic [CW-1:0] period_cnt_out;

  clk_gen_div_if #(.DIV_WIDTH(DW)) cfg_if ();

  clk_gen_div #(
    .DIV_WIDTH(DW),
    .DIV_RESET(0),
    .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .en_in         (en_in),
    .cfg           (cfg_if.slave),
    .clk_out       (clk_out),
    .running_out   (running_out),
    .period_cnt_out(period_cnt_out)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_check(input string name, input int g);
    n_checks++;
    if (g >= LIMIT) begin
      n_errors++;
      $display("FAIL %s: no event within %0d cycles", name, LIMIT);
    end
  endtask

  // Model: tracks cycles left in the current phase rather than a compare counter.
  logic          m_run, m_hi, m_pfull, m_s1, m_s2;
  logic [DW-1:0] m_div, m_pend;
  logic [CW-1:0] m_pcnt;
  int            m_left;

  always @(posedge clk or negedge reset_n) begin
    logic acc, en_eff;
    if (!reset_n) begin
      m_run = 0; m_hi = 0; m_pfull = 0; m_s1 = 0; m_s2 = 0;
      m_div = '0; m_pend = '0; m_pcnt = '0; m_left = 0;
      sb_q.delete();
    end else begin
      acc = cfg_if.cfg_valid_in && !m_pfull;
`ifdef CLK_GEN_DIV_SYNC_EN
      en_eff = m_s2; m_s2 = m_s1; m_s1 = en_in;
`else
      en_eff = en_in;
`endif
      if (!m_run) begin
        if (en_eff) begin
          m_run = 1; m_hi = 1; m_left = m_div + 1;
        end else if (m_pfull) begin
          m_div = m_pend; m_pfull = 0;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_hi) begin
            m_hi = 0; m_left = m_div + 1;
          end else begin
            m_pcnt++;
            if (!en_eff) m_run = 0;
            else begin
              if (m_pfull) begin m_div = m_pend; m_pfull = 0; end
              m_hi = 1; m_left = m_div + 1;
            end
          end
        end
      end
      if (acc) begin m_pend = cfg_if.cfg_div_in; m_pfull = 1; end
      sb_q.push_back('{clk_out: m_run && m_hi, running: m_run, ready: !m_pfull, pcnt: m_pcnt});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("scoreboard{clk,run,rdy,pcnt}", {clk_out, running_out, cfg_if.cfg_ready_out, period_cnt_out}, e);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_cfg(input int d);
    int g = 0;
    cfg_if.cfg_valid_in = 1'b1;
    cfg_if.cfg_div_in   = DW'(d);
    while (!cfg_if.cfg_ready_out && g < LIMIT) begin cycles(1); g++; end
    bound_check("send_cfg", g);
    cycles(1);
    cfg_if.cfg_valid_in = 1'b0;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!cfg_if.cfg_ready_out && g < LIMIT) begin cycles(1); g++; end
    bound_check("wait_ready", g);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (running_out && g < LIMIT) begin cycles(1); g++; end
    bound_check("wait_idle", g);
  endtask

  task automatic wait_rise();
    int   g = 0;
    logic prev;
    do begin prev = clk_out; cycles(1); g++; end while (!(!prev && clk_out) && g < LIMIT);
    bound_check("wait_rise", g);
  endtask

  // Measures the next complete period that begins with a fresh rising edge (negedge samples).
  task automatic measure_period(output int hi, output int lo);
    int g = 0;
    hi = 0; lo = 0;
    @(negedge clk);
    while (clk_out !== 1'b0 && g < LIMIT) begin @(negedge clk); g++; end
    while (clk_out !== 1'b1 && g < LIMIT) begin @(negedge clk); g++; end
    while (clk_out === 1'b1 && g < LIMIT) begin hi++; @(negedge clk); g++; end
    while (clk_out === 1'b0 && g < LIMIT) begin lo++; @(negedge clk); g++; end
    bound_check("measure_period", g);
  endtask

  vec_t vecs[4];

  initial begin
    int hi, lo;
    vecs[0] = '{div: 0,   half: 1,   periods: 3};
    vecs[1] = '{div: 255, half: 256, periods: 1};
    vecs[2] = '{div: 4,   half: 5,   periods: 2};
    vecs[3] = '{div: 1,   half: 2,   periods: 2};

    reset_n = 1'b0; en_in = 1'b0;
    cfg_if.cfg_valid_in = 1'b0; cfg_if.cfg_div_in = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    check("rst_clk_out", clk_out, 0);
    check("rst_running", running_out, 0);
    check("rst_ready", cfg_if.cfg_ready_out, 1);
    check("rst_pcnt", period_cnt_out, 0);
    cycles(20);
    check("idle20_clk_out", clk_out, 0);
    check("idle20_running", running_out, 0);
    check("idle20_pcnt", period_cnt_out, 0);

    // Divide-by-2 from the reset ratio.
    en_in = 1'b1;
    cycles(1 + SYNC_LAT);
    check("start_clk_out", clk_out, 1);
    check("start_running", running_out, 1);
    cycles(1);
    check("div2_low", clk_out, 0);
    cycles(19);
    check("div2_pcnt10", period_cnt_out, 10);
    check("div2_high", clk_out, 1);

    // Ratio change while running applies at the next boundary.
    send_cfg(3);
    check("cfg_pend_ready", cfg_if.cfg_ready_out, 0);
    wait_ready();
    check("cfg_applied_ready", cfg_if.cfg_ready_out, 1);
    measure_period(hi, lo);
    check("d3_hi", hi, 4);
    check("d3_lo", lo, 4);

    // Second offer stalls while the slot is full; the held value lands a boundary later.
    send_cfg(2);
    cfg_if.cfg_valid_in = 1'b1; cfg_if.cfg_div_in = DW'(1);
    check("stall_ready", cfg_if.cfg_ready_out, 0);
    cycles(2);
    check("stall_ready_held", cfg_if.cfg_ready_out, 0);
    wait_ready();
    cycles(1);
    cfg_if.cfg_valid_in = 1'b0;
    check("stall_accepted", cfg_if.cfg_ready_out, 0);
    measure_period(hi, lo);
    check("d1_hi", hi, 2);
    check("d1_lo", lo, 2);

    // Stop requested one cycle into a D=2 high phase.
    send_cfg(2);
    wait_ready();
    cycles(1);
    en_in = 1'b0;
    cycles(1);
    check("stop_hi_completes", clk_out, 1);
    cycles(1);
    check("stop_lo_clk", clk_out, 0);
    check("stop_lo_running", running_out, 1);
    cycles(2);
    check("stop_lo_still_running", running_out, 1);
    cycles(1);
    check("stop_idle_running", running_out, 0);
    check("stop_idle_clk", clk_out, 0);
    cycles(10);
    check("stop_hold_clk", clk_out, 0);
    check("stop_hold_running", running_out, 0);

    // Table: ratio loaded in IDLE, then whole periods measured.
    for (int i = 0; i < 4; i++) begin
      send_cfg(vecs[i].div);
      cycles(1);
      en_in = 1'b1;
      for (int p = 0; p < vecs[i].periods; p++) begin
        measure_period(hi, lo);
        check($sformatf("vec%0d_hi", i), hi, vecs[i].half);
        check($sformatf("vec%0d_lo", i), lo, vecs[i].half);
      end
      en_in = 1'b0;
      wait_idle();
    end

    // Start coinciding with a config accept keeps the old ratio for the first period.
    en_in = 1'b1;
    cfg_if.cfg_valid_in = 1'b1; cfg_if.cfg_div_in = DW'(5);
    fork
      measure_period(hi, lo);
      begin cycles(1); cfg_if.cfg_valid_in = 1'b0; end
    join
    check("startcfg_first_hi", hi, (SYNC_LAT != 0) ? 6 : 2);
    check("startcfg_first_lo", lo, (SYNC_LAT != 0) ? 6 : 2);
    measure_period(hi, lo);
    check("startcfg_next_hi", hi, 6);
    check("startcfg_next_lo", lo, 6);
    en_in = 1'b0;
    wait_idle();

    // Async reset in the middle of a high phase.
    send_cfg(3);
    cycles(1);
    en_in = 1'b1;
    wait_rise();
    cycles(1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_clk", clk_out, 0);
    check("async_rst_running", running_out, 0);
    check("async_rst_ready", cfg_if.cfg_ready_out, 1);
    check("async_rst_pcnt", period_cnt_out, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    cycles(1 + SYNC_LAT);
    check("restart_clk", clk_out, 1);
    cycles(1);
    check("restart_div2_low", clk_out, 0);

    // Period counter wrap with a 4-bit counter.
    cycles(1);
    for (int k = 1; k <= 17; k++) begin
      check($sformatf("wrap_pcnt_%0d", k), period_cnt_out, k % 16);
      cycles(2);
    end

    en_in = 1'b0;
    cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
